// File: rtl/xor_bus_master.sv
// Bus master for the XOR target: pushes operand A and B, pops the result Y and returns it
// as a single response, giving up with rsp_err when a status poll never succeeds.
module xor_bus_master #(
    parameter int unsigned POLL_LIMIT = 16
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_a,
    input  logic       cmd_b,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_data,
    output logic       rsp_err,
    output logic       write_en,
    output logic [2:0] write_address,
    output logic       write_data,
    input  logic       write_rdy,
    output logic       read_en,
    output logic [2:0] read_address,
    input  logic       read_data,
    input  logic       read_rdy,
    output logic [7:0] done_count
);

    localparam logic [7:0] LastPoll = 8'(POLL_LIMIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StPollA,
        StWrA,
        StPollB,
        StWrB,
        StPollY,
        StRdY,
        StResp
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] poll_cnt_q, poll_cnt_d;
    logic       a_q, a_d;
    logic       b_q, b_d;
    logic       data_q, data_d;
    logic       err_q, err_d;
    logic [7:0] done_q, done_d;
    logic       live_q;
    logic       poll_fail;

    // Holds cmd_ready low until the first clock edge after reset release.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            live_q <= 1'b0;
        end else begin
            live_q <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= StIdle;
            poll_cnt_q <= 8'd0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            data_q     <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            poll_cnt_q <= poll_cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            data_q     <= data_d;
            err_q      <= err_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        poll_cnt_d = poll_cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        data_d     = data_q;
        err_d      = err_q;
        done_d     = done_q;
        poll_fail  = 1'b0;

        case (state_q)
            StIdle: begin
                if (cmd_valid && live_q) begin
                    a_d        = cmd_a;
                    b_d        = cmd_b;
                    poll_cnt_d = 8'd0;
                    state_d    = StPollA;
                end
            end
            StPollA: begin
                if (read_rdy && read_data) state_d = StWrA;
                else                       poll_fail = 1'b1;
            end
            StWrA: begin
                if (write_rdy) begin
                    poll_cnt_d = 8'd0;
                    state_d    = StPollB;
                end
            end
            StPollB: begin
                if (read_rdy && read_data) state_d = StWrB;
                else                       poll_fail = 1'b1;
            end
            StWrB: begin
                if (write_rdy) begin
                    poll_cnt_d = 8'd0;
                    state_d    = StPollY;
                end
            end
            StPollY: begin
                if (read_rdy && read_data) state_d = StRdY;
                else                       poll_fail = 1'b1;
            end
            StRdY: begin
                if (read_rdy) begin
                    data_d  = read_data;
                    err_d   = 1'b0;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    done_d  = done_q + 8'd1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Shared timeout for all three poll states.
        if (poll_fail) begin
            if (poll_cnt_q >= LastPoll) begin
                data_d  = 1'b0;
                err_d   = 1'b1;
                state_d = StResp;
            end else begin
                poll_cnt_d = poll_cnt_q + 8'd1;
            end
        end
    end

    // Bus and handshake outputs depend on registered state only.
    always_comb begin
        write_en      = 1'b0;
        write_address = 3'd0;
        write_data    = 1'b0;
        read_en       = 1'b0;
        read_address  = 3'd0;
        cmd_ready     = 1'b0;
        rsp_valid     = 1'b0;
        rsp_data      = 1'b0;
        rsp_err       = 1'b0;

        case (state_q)
            StIdle:  cmd_ready = live_q;
            StPollA: begin
                read_en      = 1'b1;
                read_address = 3'd0;
            end
            StWrA: begin
                write_en      = 1'b1;
                write_address = 3'd4;
                write_data    = a_q;
            end
            StPollB: begin
                read_en      = 1'b1;
                read_address = 3'd1;
            end
            StWrB: begin
                write_en      = 1'b1;
                write_address = 3'd5;
                write_data    = b_q;
            end
            StPollY: begin
                read_en      = 1'b1;
                read_address = 3'd2;
            end
            StRdY: begin
                read_en      = 1'b1;
                read_address = 3'd3;
            end
            StResp: begin
                rsp_valid = 1'b1;
                rsp_data  = data_q;
                rsp_err   = err_q;
            end
            default: ;
        endcase
    end

    assign done_count = done_q;

endmodule
